// File: rtl/noc_packet_sink_if.sv
// Flit port between a router local output and the packet sink.
// The master side drives per-VC flits, the slave side returns per-VC accepts.
interface noc_packet_sink_if #(
    parameter int VC_NUM = 4,
    parameter int DATA_W = 64
);
    logic [VC_NUM-1:0]             flit_valid;
    logic [VC_NUM-1:0][DATA_W+1:0] flit;
    logic [VC_NUM-1:0]             flit_ready;

    modport master (output flit_valid, output flit, input flit_ready);
    modport slave  (input flit_valid, input flit, output flit_ready);
endinterface

// File: rtl/noc_packet_sink.sv
// Endpoint receive side of the NoC: VC arbitration, destination check,
// header/tail stripping, body payload streaming and packet event reporting.
module noc_sink_vc_dec #(
    parameter int              DATA_W = 64,
    parameter int              MARK_W = 8,
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] MY_ID  = '0
) (
    input  logic [DATA_W+1:0] flit,
    output logic              hdr,
    output logic              tail,
    output logic              dest_hit,
    output logic [ID_W-1:0]   src
);
    assign hdr      = flit[DATA_W+1];
    assign tail     = flit[DATA_W];
    assign src      = flit[DATA_W-MARK_W-1 -: ID_W];
    assign dest_hit = (flit[DATA_W-MARK_W-ID_W-1 -: ID_W] == MY_ID);
endmodule

module noc_packet_sink #(
    parameter int VC_NUM = 4,
    parameter int DATA_W = 64,
    parameter int ID_X_W = 2,
    parameter int ID_Y_W = 2,
    parameter int MARK_W = 8,
    parameter int MY_X   = 0,
    parameter int MY_Y   = 0
) (
    input  logic                noc_clk,
    input  logic                noc_rst_n,
    noc_packet_sink_if.slave    flit_if,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    input  logic                out_ready,
    output logic                pkt_start,
    output logic [ID_X_W-1:0]   pkt_src_x,
    output logic [ID_Y_W-1:0]   pkt_src_y,
    output logic                pkt_done,
    output logic [15:0]         pkt_cnt,
    output logic [15:0]         drop_cnt
);
    localparam int              ID_W  = ID_X_W + ID_Y_W;
    localparam int              PTR_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam logic [ID_W-1:0] MY_ID = {MY_X[ID_X_W-1:0], MY_Y[ID_Y_W-1:0]};

    typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

    state_t                     state_q, state_d;
    logic [PTR_W-1:0]           sel_q, sel_d, rr_q, rr_d, win;
    logic                       win_vld;
    logic [VC_NUM-1:0]          hdr, tail, hit, ready;
    logic [VC_NUM-1:0][ID_W-1:0] src;
    logic                       cur_vld, load, start_d, done_d;
    logic                       cnt_inc, drop_inc, latch_src;
    logic [DATA_W-1:0]          cur_data;

    for (genvar v = 0; v < VC_NUM; v++) begin : g_dec
        noc_sink_vc_dec #(
            .DATA_W (DATA_W),
            .MARK_W (MARK_W),
            .ID_W   (ID_W),
            .MY_ID  (MY_ID)
        ) u_dec (
            .flit     (flit_if.flit[v]),
            .hdr      (hdr[v]),
            .tail     (tail[v]),
            .dest_hit (hit[v]),
            .src      (src[v])
        );
    end

    // Round-robin: search begins one past the last winner.
    always_comb begin
        win     = rr_q;
        win_vld = 1'b0;
        for (int i = 1; i <= VC_NUM; i++) begin
            int idx;
            idx = (int'(rr_q) + i) % VC_NUM;
            if (!win_vld && flit_if.flit_valid[idx] && hdr[idx]) begin
                win_vld = 1'b1;
                win     = PTR_W'(idx);
            end
        end
    end

    assign cur_vld  = flit_if.flit_valid[sel_q];
    assign cur_data = flit_if.flit[sel_q][DATA_W-1:0];

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_d      = rr_q;
        ready     = '0;
        load      = 1'b0;
        start_d   = 1'b0;
        done_d    = 1'b0;
        cnt_inc   = 1'b0;
        drop_inc  = 1'b0;
        latch_src = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    ready[win] = 1'b1;
                    sel_d      = win;
                    rr_d       = win;
                    if (hit[win]) begin
                        start_d   = 1'b1;
                        latch_src = 1'b1;
                        if (tail[win]) begin
                            done_d  = 1'b1;
                            cnt_inc = 1'b1;
                        end else begin
                            state_d = BODY;
                        end
                    end else if (tail[win]) begin
                        drop_inc = 1'b1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            BODY: begin
                if (cur_vld) begin
                    // A header here aborts the packet; it is left on the VC to be re-arbitrated.
                    if (hdr[sel_q]) begin
                        drop_inc = 1'b1;
                        state_d  = IDLE;
                    end else if (!out_valid || out_ready) begin
                        ready[sel_q] = 1'b1;
                        if (tail[sel_q]) begin
                            done_d  = 1'b1;
                            cnt_inc = 1'b1;
                            state_d = IDLE;
                        end else begin
                            load = 1'b1;
                        end
                    end
                end
            end
            DROP: begin
                ready[sel_q] = 1'b1;
                if (cur_vld && tail[sel_q]) begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign flit_if.flit_ready = ready;

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            pkt_start <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_src_x <= '0;
            pkt_src_y <= '0;
            pkt_cnt   <= '0;
            drop_cnt  <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= cur_data;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            pkt_start <= start_d;
            pkt_done  <= done_d;
            if (latch_src) begin
                pkt_src_x <= src[win][ID_W-1 -: ID_X_W];
                pkt_src_y <= src[win][ID_Y_W-1:0];
            end
            if (cnt_inc && pkt_cnt != 16'hFFFF)
                pkt_cnt <= pkt_cnt + 16'd1;
            if (drop_inc && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_noc_packet_sink.sv
// Directed table-driven bench for noc_packet_sink (MY = (0,0)), plus a
// hand-written mid-packet reset sequence.
module tb_noc_packet_sink;
    logic        noc_clk = 1'b0;
    logic        noc_rst_n = 1'b0;
    logic        out_valid, out_ready, pkt_start, pkt_done;
    logic [63:0] out_data;
    logic [1:0]  pkt_src_x, pkt_src_y;
    logic [15:0] pkt_cnt, drop_cnt;
    int          n_vec = 0;
    int          n_bad = 0;

    noc_packet_sink_if #(.VC_NUM(4), .DATA_W(64)) fif ();

    noc_packet_sink dut (
        .noc_clk   (noc_clk),
        .noc_rst_n (noc_rst_n),
        .flit_if   (fif.slave),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .pkt_start (pkt_start),
        .pkt_src_x (pkt_src_x),
        .pkt_src_y (pkt_src_y),
        .pkt_done  (pkt_done),
        .pkt_cnt   (pkt_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 noc_clk = ~noc_clk;

    typedef struct {
        logic [3:0]  fv, hd, tl;
        logic [63:0] d;
        logic        ordy;
        logic [3:0]  efr;
        logic        eov;
        logic [63:0] eod;
        logic        eps, epd;
    } vec_t;

    vec_t q[$];

    function automatic logic [63:0] H(input logic [1:0] sx, sy, dx, dy);
        return {8'hA5, sx, sy, dx, dy, 48'h0};
    endfunction

    function automatic vec_t V(input logic [3:0] fv, hd, tl, input logic [63:0] d,
                               input logic ordy, input logic [3:0] efr, input logic eov,
                               input logic [63:0] eod, input logic eps, epd);
        vec_t r;
        r.fv = fv; r.hd = hd; r.tl = tl; r.d = d; r.ordy = ordy;
        r.efr = efr; r.eov = eov; r.eod = eod; r.eps = eps; r.epd = epd;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Each VC carries the same record data with its VC index in the low nibble.
    task automatic drive(input logic [3:0] fv, hd, tl, input logic [63:0] d);
        fif.flit_valid = fv;
        for (int v = 0; v < 4; v++)
            fif.flit[v] = {hd[v], tl[v], d | 64'(v)};
    endtask

    task automatic run_table(input string tag);
        for (int k = 0; k < q.size(); k++) begin
            @(negedge noc_clk);
            drive(q[k].fv, q[k].hd, q[k].tl, q[k].d);
            out_ready = q[k].ordy;
            #1 chk($sformatf("%s[%0d] flit_ready", tag, k), 64'(fif.flit_ready), 64'(q[k].efr));
            @(posedge noc_clk);
            #1;
            chk($sformatf("%s[%0d] out_valid", tag, k), 64'(out_valid), 64'(q[k].eov));
            if (q[k].eov)
                chk($sformatf("%s[%0d] out_data", tag, k), out_data, q[k].eod);
            chk($sformatf("%s[%0d] pkt_start", tag, k), 64'(pkt_start), 64'(q[k].eps));
            chk($sformatf("%s[%0d] pkt_done", tag, k), 64'(pkt_done), 64'(q[k].epd));
        end
        q.delete();
    endtask

    task automatic chk_state(input string tag, input logic [15:0] pc, dc,
                             input logic [1:0] sx, sy);
        chk({tag, " pkt_cnt"}, 64'(pkt_cnt), 64'(pc));
        chk({tag, " drop_cnt"}, 64'(drop_cnt), 64'(dc));
        chk({tag, " pkt_src_x"}, 64'(pkt_src_x), 64'(sx));
        chk({tag, " pkt_src_y"}, 64'(pkt_src_y), 64'(sy));
    endtask

    localparam logic [63:0] B1 = 64'h1111_0000_0000_0010;
    localparam logic [63:0] B2 = 64'h2222_0000_0000_0020;
    localparam logic [63:0] B3 = 64'h3333_0000_0000_0030;
    localparam logic [63:0] TL = 64'hEEEE_0000_0000_00F0;

    initial begin
        drive(4'h0, 4'h0, 4'h0, 64'h0);
        out_ready = 1'b1;
        #2;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset flit_ready", 64'(fif.flit_ready), 64'd0);
        chk_state("reset", 16'd0, 16'd0, 2'd0, 2'd0);
        @(negedge noc_clk);
        noc_rst_n = 1'b1;

        // Single packet on VC0
        q.push_back(V(4'h1, 4'h1, 4'h0, H(1,2,0,0), 1, 4'h1, 0, 0,  1, 0));
        q.push_back(V(4'h1, 4'h0, 4'h0, B1,         1, 4'h1, 1, B1, 0, 0));
        q.push_back(V(4'h1, 4'h0, 4'h0, B2,         1, 4'h1, 1, B2, 0, 0));
        q.push_back(V(4'h1, 4'h0, 4'h0, B3,         1, 4'h1, 1, B3, 0, 0));
        q.push_back(V(4'h1, 4'h0, 4'h1, TL,         1, 4'h1, 0, 0,  0, 1));
        q.push_back(V(4'h0, 4'h0, 4'h0, 64'h0,      1, 4'h0, 0, 0,  0, 0));
        run_table("single");
        chk_state("single", 16'd1, 16'd0, 2'd1, 2'd2);

        // Backpressure: beat 2 held five cycles
        q.push_back(V(4'h1, 4'h1, 4'h0, H(1,2,0,0), 1, 4'h1, 0, 0,  1, 0));
        q.push_back(V(4'h1, 4'h0, 4'h0, B1,         1, 4'h1, 1, B1, 0, 0));
        q.push_back(V(4'h1, 4'h0, 4'h0, B2,         1, 4'h1, 1, B2, 0, 0));
        for (int i = 0; i < 5; i++)
            q.push_back(V(4'h1, 4'h0, 4'h0, B3,     0, 4'h0, 1, B2, 0, 0));
        q.push_back(V(4'h1, 4'h0, 4'h0, B3,         1, 4'h1, 1, B3, 0, 0));
        q.push_back(V(4'h1, 4'h0, 4'h1, TL,         1, 4'h1, 0, 0,  0, 1));
        q.push_back(V(4'h0, 4'h0, 4'h0, 64'h0,      1, 4'h0, 0, 0,  0, 0));
        run_table("bp");
        chk_state("bp", 16'd2, 16'd0, 2'd1, 2'd2);

        // Destination mismatch: whole packet consumed and dropped
        q.push_back(V(4'h1, 4'h1, 4'h0, H(2,3,1,0), 1, 4'h1, 0, 0, 0, 0));
        q.push_back(V(4'h1, 4'h0, 4'h0, B1,         0, 4'h1, 0, 0, 0, 0));
        q.push_back(V(4'h1, 4'h0, 4'h0, B2,         0, 4'h1, 0, 0, 0, 0));
        q.push_back(V(4'h1, 4'h0, 4'h1, TL,         0, 4'h1, 0, 0, 0, 0));
        q.push_back(V(4'h0, 4'h0, 4'h0, 64'h0,      1, 4'h0, 0, 0, 0, 0));
        run_table("drop");
        chk_state("drop", 16'd2, 16'd1, 2'd1, 2'd2);

        // Two VCs request together: VC1 completes before VC2 is granted
        q.push_back(V(4'h6, 4'h6, 4'h0, H(0,1,0,0), 1, 4'h2, 0, 0,       1, 0));
        q.push_back(V(4'h6, 4'h4, 4'h0, B1,         1, 4'h2, 1, B1|64'd1, 0, 0));
        q.push_back(V(4'h6, 4'h4, 4'h2, TL,         1, 4'h2, 0, 0,       0, 1));
        q.push_back(V(4'h4, 4'h4, 4'h0, H(3,3,0,0), 1, 4'h4, 0, 0,       1, 0));
        q.push_back(V(4'h4, 4'h0, 4'h0, B2,         1, 4'h4, 1, B2|64'd2, 0, 0));
        q.push_back(V(4'h4, 4'h0, 4'h4, TL,         1, 4'h4, 0, 0,       0, 1));
        q.push_back(V(4'h0, 4'h0, 4'h0, 64'h0,      1, 4'h0, 0, 0,       0, 0));
        run_table("twovc");
        chk_state("twovc", 16'd4, 16'd1, 2'd3, 2'd3);

        // Zero-payload packet on VC3
        q.push_back(V(4'h8, 4'h8, 4'h8, H(2,1,0,0), 1, 4'h8, 0, 0, 1, 1));
        q.push_back(V(4'h0, 4'h0, 4'h0, 64'h0,      1, 4'h0, 0, 0, 0, 0));
        run_table("hdrtail");
        chk_state("hdrtail", 16'd5, 16'd1, 2'd2, 2'd1);

        // Header inside a body aborts the packet and is re-arbitrated
        q.push_back(V(4'h1, 4'h1, 4'h0, H(3,0,0,0), 1, 4'h1, 0, 0,  1, 0));
        q.push_back(V(4'h1, 4'h0, 4'h0, B1,         1, 4'h1, 1, B1, 0, 0));
        q.push_back(V(4'h1, 4'h1, 4'h0, H(1,1,0,0), 1, 4'h0, 0, 0,  0, 0));
        q.push_back(V(4'h1, 4'h1, 4'h0, H(1,1,0,0), 1, 4'h1, 0, 0,  1, 0));
        q.push_back(V(4'h1, 4'h0, 4'h0, B2,         1, 4'h1, 1, B2, 0, 0));
        q.push_back(V(4'h1, 4'h0, 4'h1, TL,         1, 4'h1, 0, 0,  0, 1));
        run_table("abort");
        chk_state("abort", 16'd6, 16'd2, 2'd1, 2'd1);

        // Asynchronous reset mid-body with a beat stalled in the out register
        @(negedge noc_clk);
        drive(4'h1, 4'h1, 4'h0, H(1,3,0,0));
        out_ready = 1'b0;
        @(posedge noc_clk);
        #1 chk("rst pre pkt_start", 64'(pkt_start), 64'd1);
        @(negedge noc_clk);
        drive(4'h1, 4'h0, 4'h0, B1);
        @(posedge noc_clk);
        #1 chk("rst pre out_data", out_data, B1);
        @(negedge noc_clk);
        drive(4'h1, 4'h0, 4'h0, B2);
        #2 noc_rst_n = 1'b0;
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data", out_data, 64'd0);
        chk("rst pkt_start", 64'(pkt_start), 64'd0);
        chk("rst pkt_done", 64'(pkt_done), 64'd0);
        chk("rst headerless flit_ready", 64'(fif.flit_ready), 64'd0);
        chk_state("rst", 16'd0, 16'd0, 2'd0, 2'd0);
        @(negedge noc_clk);
        noc_rst_n = 1'b1;
        out_ready = 1'b1;
        #1 chk("post-rst stall flit_ready", 64'(fif.flit_ready), 64'd0);
        @(posedge noc_clk);
        #1 chk("post-rst out_valid", 64'(out_valid), 64'd0);
        @(negedge noc_clk);
        fif.flit_valid = 4'h3;
        fif.flit[1] = {1'b1, 1'b1, H(0,2,0,0)};
        #1 chk("post-rst grant vc1", 64'(fif.flit_ready), 64'h2);
        @(posedge noc_clk);
        #1;
        chk("post-rst pkt_start", 64'(pkt_start), 64'd1);
        chk("post-rst pkt_done", 64'(pkt_done), 64'd1);
        chk_state("post-rst", 16'd1, 16'd0, 2'd0, 2'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
